// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - shared op encoding for the pipelined bitwise logic unit
package logic_unit_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_NOR   = 3'b011,
        OP_NAND  = 3'b100,
        OP_XNOR  = 3'b101,
        OP_ANDN  = 3'b110,
        OP_PASSA = 3'b111
    } op_e;

endpackage

// File: rtl/logic_unit_core.sv
// rtl/logic_unit_core.sv - combinational bitwise operation selected by op
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op_e'(op))
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_NOR:   result = ~(a | b);
            OP_NAND:  result = ~(a & b);
            OP_XNOR:  result = ~(a ^ b);
            OP_ANDN:  result = a & ~b;
            OP_PASSA: result = a;
            default:  result = a;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage valid/ready bitwise logic unit with flags and op counter
// Optional zero/parity flags are built only when LOGIC_UNIT_FLAGS_EN is defined.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_parity,
    output logic [CNT_W-1:0] ops_done
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [OP_W-1:0]  s1_op;
    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic [WIDTH-1:0] core_result;
    logic             s1_en;
    logic             s2_en;

    // Ready ripples back combinationally so a full pipe still streams at one per cycle.
    assign s2_en    = !s2_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_op    <= in_op;
        end
    end

    logic_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (s1_a),
        .b      (s1_b),
        .op     (s1_op),
        .result (core_result)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
        end else if (s2_en) begin
            s2_valid  <= s1_valid;
            s2_result <= core_result;
        end
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    logic s2_zero;
    logic s2_parity;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s2_zero   <= 1'b1;
            s2_parity <= 1'b0;
        end else if (s2_en) begin
            s2_zero   <= ~|core_result;
            s2_parity <= ^core_result;
        end
    end

    assign out_zero   = s2_zero;
    assign out_parity = s2_parity;
`else
    assign out_zero   = 1'b0;
    assign out_parity = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ops_done <= '0;
        end else if (s2_valid && out_ready) begin
            ops_done <= ops_done + CNT_W'(1);
        end
    end

    assign out_valid  = s2_valid;
    assign out_result = s2_result;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - directed vector bench for logic_unit_pipe
module tb_logic_unit_pipe;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_op;
    logic        out_ready;

    logic        in_ready,  in_ready2;
    logic        out_valid, out_valid2;
    logic [31:0] out_result, out_result2;
    logic        out_zero,  out_zero2;
    logic        out_parity, out_parity2;
    logic [15:0] ops_done;
    logic [1:0]  ops_done2;

    always #5 clock = ~clock;

    logic_unit_pipe #(.WIDTH(32), .CNT_W(16)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_parity(out_parity),
        .ops_done(ops_done)
    );

    logic_unit_pipe #(.WIDTH(32), .CNT_W(2)) u_dut_w2 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_result(out_result2), .out_zero(out_zero2), .out_parity(out_parity2),
        .ops_done(ops_done2)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[10];

    int n_cmp = 0;
    int n_bad = 0;

    logic        m_s1v, m_s2v;
    logic [31:0] m_s1r, m_s2r;
    logic [15:0] exp_cnt;

`ifdef LOGIC_UNIT_FLAGS_EN
    localparam logic RST_ZERO = 1'b1;
`else
    localparam logic RST_ZERO = 1'b0;
`endif

    function automatic logic f_zero(input logic [31:0] r);
`ifdef LOGIC_UNIT_FLAGS_EN
        return (r == 32'h0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic f_par(input logic [31:0] r);
`ifdef LOGIC_UNIT_FLAGS_EN
        return ^r;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b0;
        reset_n   = 1'b0;
        m_s1v = 1'b0; m_s2v = 1'b0; m_s1r = '0; m_s2r = '0;
        exp_cnt = '0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // One clock: drive at negedge, check against the two-slot reference, advance the reference.
    task automatic step(input logic v, input vec_t x, input logic ordy, output logic acc);
        logic s1e, s2e;
        in_valid  = v;
        in_op     = x.op;
        in_a      = x.a;
        in_b      = x.b;
        out_ready = ordy;
        #1;
        s2e = !m_s2v || ordy;
        s1e = !m_s1v || s2e;
        chk("in_ready", 32'(in_ready), 32'(s1e));
        chk("in_ready_w2", 32'(in_ready2), 32'(s1e));
        chk("out_valid", 32'(out_valid), 32'(m_s2v));
        if (m_s2v) begin
            chk("out_result", out_result, m_s2r);
            chk("out_zero", 32'(out_zero), 32'(f_zero(m_s2r)));
            chk("out_parity", 32'(out_parity), 32'(f_par(m_s2r)));
            if (ordy) exp_cnt = exp_cnt + 16'd1;
        end
        acc = v && s1e;
        if (s2e) begin m_s2v = m_s1v; m_s2r = m_s1r; end
        if (s1e) begin m_s1v = v; m_s1r = x.res; end
        @(posedge clock);
        @(negedge clock);
        chk("ops_done", 32'(ops_done), 32'(exp_cnt));
        chk("ops_done_w2", 32'(ops_done2), 32'(exp_cnt[1:0]));
    endtask

    vec_t idle;
    logic acc;
    int   idx;
    int   guard;

    initial begin
        vecs[0] = '{3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234};
        vecs[1] = '{3'b001, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF};
        vecs[2] = '{3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB};
        vecs[3] = '{3'b011, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h000F_0000};
        vecs[4] = '{3'b100, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF0F_EDCB};
        vecs[5] = '{3'b101, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00FF_1234};
        vecs[6] = '{3'b110, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hF000_0000};
        vecs[7] = '{3'b111, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hF0F0_1234};
        vecs[8] = '{3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[9] = '{3'b001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001};
        idle    = '{3'b000, 32'h0, 32'h0, 32'h0};

        // Reset state
        do_reset();
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_out_zero", 32'(out_zero), 32'(RST_ZERO));
        chk("rst_out_parity", 32'(out_parity), 32'd0);
        chk("rst_ops_done", 32'(ops_done), 32'd0);
        @(negedge clock);

        // All ops and flag vectors, streamed back to back
        for (int i = 0; i < 10; i++) begin
            step(1'b1, vecs[i], 1'b1, acc);
            chk("stream_accept", 32'(acc), 32'd1);
        end
        for (int i = 0; i < 3; i++) step(1'b0, idle, 1'b1, acc);
        chk("stream_count", 32'(ops_done), 32'd10);

        // Backpressure: four bundles with the consumer stalled
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, vecs[idx], 1'b0, acc);
            if (acc) idx++;
        end
        chk("bp_accepts", 32'(idx), 32'd2);
        guard = 0;
        while (idx < 4 && guard < 20) begin
            step(1'b1, vecs[idx], 1'b1, acc);
            if (acc) idx++;
            guard++;
        end
        chk("bp_drain_bound", 32'(idx), 32'd4);
        for (int i = 0; i < 3; i++) step(1'b0, idle, 1'b1, acc);
        chk("bp_count", 32'(ops_done), 32'd14);

        // Counter wrap on the 2-bit instance
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, vecs[i], 1'b1, acc);
        for (int i = 0; i < 3; i++) step(1'b0, idle, 1'b1, acc);
        chk("wrap_final_w2", 32'(ops_done2), 32'd1);
        chk("wrap_final", 32'(ops_done), 32'd5);

        // Reset with both stages full
        step(1'b1, vecs[2], 1'b0, acc);
        step(1'b1, vecs[3], 1'b0, acc);
        chk("mid_full", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_ops_done", 32'(ops_done), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd1);
        m_s1v = 1'b0; m_s2v = 1'b0; m_s1r = '0; m_s2r = '0;
        exp_cnt = '0;
        @(negedge clock);
        reset_n = 1'b1;

        // Two-cycle latency after release
        step(1'b1, vecs[6], 1'b1, acc);
        chk("lat_accept", 32'(acc), 32'd1);
        chk("lat_c1", 32'(out_valid), 32'd0);
        step(1'b0, idle, 1'b1, acc);
        chk("lat_c2", 32'(out_valid), 32'd1);
        chk("lat_result", out_result, 32'hF000_0000);
        step(1'b0, idle, 1'b1, acc);
        step(1'b0, idle, 1'b1, acc);
        chk("lat_count", 32'(ops_done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

- Parametrised, two-stage pipelined bitwise logic unit with a valid/ready handshake on both sides.
- Generalises the fixed 32-bit OR gate array in three ways:
  - selectable operand width;
  - eight selectable bitwise operations;
  - zero/parity flags and a completed-operation counter.
- Sits in the execute stage beside the adder and shifter.
- Accepts one operation per cycle under no backpressure; results appear two cycles after acceptance.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits (≥1).
- CNT_W, 16, width of the completed-operation counter (≥1).

Ports:
- clock  in  1  rising-edge clock for all state.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  unit can accept the bundle this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  3  operation select.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result this cycle.
- out_result  out  WIDTH  bitwise result.
- out_zero  out  1  out_result is all zeros.
- out_parity  out  1  XOR-reduction of out_result.
- ops_done  out  CNT_W  count of results consumed.

Clock and reset: one clock; reset is asynchronous and active-low (`clock`, `reset_n`).

## Operation
Op encoding (in_op):

| in_op | Operation |
|---|---|
| 000 | AND: A&B |
| 001 | OR: A\|B |
| 010 | XOR: A^B |
| 011 | NOR: ~(A\|B) |
| 100 | NAND: ~(A&B) |
| 101 | XNOR: ~(A^B) |
| 110 | ANDN: A&~B |
| 111 | PASSA: A |

Pipeline stages:
- Stage 1 (s1) registers in_a, in_b and in_op, plus s1_valid.
- Stage 2 (s2) registers the computed result and flags, plus s2_valid.

Handshake and advance rules:
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- s2 advance: s2_en = !s2_valid || out_ready.
- s1 advance: s1_en = !s1_valid || s2_en.
- in_ready = s1_en, combinational from out_ready. No register is inserted on the ready path.
- When s1_en is asserted, s1_valid takes in_valid and the s1 data registers load.
- When s2_en is asserted, s2_valid takes s1_valid and the s2 data load from s1.
- Data registers may load on any enable, whether or not the stage is valid. The bench must ignore out_result/flags when out_valid = 0.

Outputs and counter:
- out_valid = s2_valid. While out_valid && !out_ready, out_result, flags and out_valid hold stable.
- ops_done increments by 1 on each output transfer and wraps modulo 2^CNT_W (all-ones goes to 0).
- Arithmetic: none. Width is preserved end to end; no carries; the result is exactly WIDTH bits.

Boundary conditions:
- Both stages full and out_ready = 1: accept one, emit one, same cycle; throughput is maintained.
- Both stages full and out_ready = 0: in_ready = 0; the input bundle must be held by the producer.
- Empty pipe: in_ready = 1 regardless of out_ready.
- Reset mid-operation: all valids clear and in-flight operations are discarded; no partial output.

## Timing
- Reset values:
  - out_valid = 0, out_result = 0, out_zero = 1, out_parity = 0, ops_done = 0.
  - in_ready = 1, since both stages are empty.
- Latency: a bundle accepted at edge N is presented at out_valid after edge N+1. That is 2 cycles from the in_valid cycle to the first out_valid cycle, without stalls.
- Throughput: 1 result per cycle while out_ready = 1.
- ops_done updates on the edge of the transfer; it is visible the following cycle.
- reset_n assertion clears state immediately (asynchronous). Deassertion is assumed synchronised upstream; the first accept occurs at the first edge with reset_n = 1.

## Configuration
- Macro LOGIC_UNIT_FLAGS_EN.
- Defined: out_zero and out_parity are computed from the stage-1 result and registered in s2 alongside out_result.
- Undefined: the flag registers and reduction logic are omitted; out_zero and out_parity are tied to 0 (including at reset).
- The result, handshake and counter are unaffected by the macro.

## Structure
- Shared package logic_unit_pkg holds:
  - op_e, a 3-bit enum: OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NAND, OP_XNOR, OP_ANDN, OP_PASSA;
  - OP_W = 3.
- One combinational sub-module, logic_unit_core (WIDTH; a, b, op → result), instanced between s1 and s2.
- Pipeline control, flags and counter live in logic_unit_pipe.

## Test plan
- Reset, then in_valid = 0: in_ready = 1, out_valid = 0, out_zero = 1 (flags enabled), ops_done = 0.
- Per-op check, WIDTH=32, out_ready = 1, A=0xF0F0_1234, B=0x0FF0_FFFF. Expected results two cycles later:

  | Op | Expected out_result |
  |---|---|
  | AND | 0x00F0_1234 |
  | OR | 0xFFF0_FFFF |
  | XOR | 0xFF00_EDCB |
  | NOR | 0x000F_0000 |
  | NAND | 0xFF0F_EDCB |
  | XNOR | 0x00FF_1234 |
  | ANDN | 0xF000_0000 |
  | PASSA | 0xF0F0_1234 |

- Flags: XOR with A=B=0xDEAD_BEEF gives out_result 0 with out_zero = 1 and out_parity = 0. OR with A=1, B=0 gives out_zero = 0 and out_parity = 1.
- Backpressure:
  - Stream 4 bundles with out_ready held 0. in_ready drops after 2 accepts, and out_result holds the first result.
  - Then raise out_ready. Results emerge in order, one per cycle, with no loss or duplication.
- Counter wrap, CNT_W=2: 5 output transfers give ops_done sequence 1, 2, 3, 0, 1.
- Reset mid-stream: assert reset_n = 0 with both stages valid. out_valid drops asynchronously, and ops_done = 0. After release, the first new result appears 2 cycles after acceptance.
